// File: rtl/afifo_wptr_full.sv
// afifo_wptr_full: write-side binary/Gray pointer, full, almost-full and fill level for the async FIFO
// Optional sticky overflow flag ovf_o enabled by defining WPTR_OVF_FLAG_EN.
module afifo_wptr_full #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  winc_i,
    input  logic [ADDR_WIDTH:0]   rptr_sync_i,
    output logic                  wen_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [ADDR_WIDTH:0]   wptr_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic [ADDR_WIDTH:0]   wlevel_o
`ifdef WPTR_OVF_FLAG_EN
    ,
    output logic                  ovf_o
`endif
);

    localparam int                PW    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] ONE   = PW'(1);
    localparam logic [ADDR_WIDTH:0] AF_TH = PW'(AFULL_THRESH);

    logic [ADDR_WIDTH:0] wbin_q, wbin_d;
    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] wlevel_q, wlevel_d;
    logic [ADDR_WIDTH:0] rbin;
    logic                full_q, full_d;
    logic                afull_q, afull_d;

    assign wen_o         = winc_i & ~full_q;
    assign waddr_o       = wbin_q[ADDR_WIDTH-1:0];
    assign wptr_o        = wptr_q;
    assign full_o        = full_q;
    assign almost_full_o = afull_q;
    assign wlevel_o      = wlevel_q;

    // Next pointer, Gray code and flags, all derived from the post-push pointer
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) rbin[i] = ^(rptr_sync_i >> i);
        wbin_d   = wbin_q + (wen_o ? ONE : '0);
        wptr_d   = wbin_d ^ (wbin_d >> 1);
        full_d   = wptr_d == {~rptr_sync_i[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync_i[ADDR_WIDTH-2:0]};
        wlevel_d = wbin_d - rbin;
        afull_d  = wlevel_d >= AF_TH;
    end

    // Pointer and flag registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
        end
    end

`ifdef WPTR_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    assign ovf_o = ovf_q;
    assign ovf_d = ovf_q | (winc_i & full_q);

    // Sticky overflow: a push attempted while full, cleared only by reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end
`endif

endmodule

// File: tb/tb_afifo_wptr_full.sv
// tb_afifo_wptr_full: scoreboard bench for the async FIFO write pointer / full logic
module tb_afifo_wptr_full;

    typedef struct {
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic [4:0] lvl;
        logic       full;
        logic       af;
        logic       wen;
        logic       ovf;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       winc_i = 1'b0;
    logic [4:0] rptr_sync_i = '0;
    logic       wen_o, full_o, almost_full_o;
    logic [3:0] waddr_o;
    logic [4:0] wptr_o, wlevel_o;
    logic       ovf_a;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   wcnt = 0;
    logic full_m = 1'b0;
    logic ovf_m = 1'b0;

    afifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
        .clk_i(clk_i),
        .rstn_i(rstn_i),
        .winc_i(winc_i),
        .rptr_sync_i(rptr_sync_i),
        .wen_o(wen_o),
        .waddr_o(waddr_o),
        .wptr_o(wptr_o),
        .full_o(full_o),
        .almost_full_o(almost_full_o),
        .wlevel_o(wlevel_o)
`ifdef WPTR_OVF_FLAG_EN
        ,
        .ovf_o(ovf_a)
`endif
    );

`ifndef WPTR_OVF_FLAG_EN
    assign ovf_a = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    function automatic logic [4:0] gray(input int x);
        logic [4:0] b;
        b = 5'(x & 31);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge and queue the state expected after the next rising edge
    task automatic step(input logic w, input int rd);
        exp_t e;
        int   lvl;
        @(negedge clk_i);
        winc_i      = w;
        rptr_sync_i = gray(rd);
        ovf_m       = ovf_m | (w & full_m);
        if (w && !full_m) wcnt = (wcnt + 1) % 32;
        lvl    = (wcnt - rd + 32) % 32;
        full_m = (lvl == 16);
        e.waddr = 4'(wcnt % 16);
        e.wptr  = gray(wcnt);
        e.lvl   = 5'(lvl);
        e.full  = full_m;
        e.af    = lvl >= 12;
        e.wen   = w & ~full_m;
`ifdef WPTR_OVF_FLAG_EN
        e.ovf   = ovf_m;
`else
        e.ovf   = 1'b0;
`endif
        q.push_back(e);
        @(posedge clk_i);
    endtask

    // Monitor: after every rising edge with a queued expectation, compare and check Gray adjacency
    always @(posedge clk_i) begin
        exp_t       e;
        logic [4:0] old;
        old = wptr_o;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (waddr_o !== e.waddr || wptr_o !== e.wptr || wlevel_o !== e.lvl || full_o !== e.full ||
                almost_full_o !== e.af || wen_o !== e.wen || ovf_a !== e.ovf) begin
                fails++;
                $display("FAIL cycle @%0t: waddr %0d/%0d wptr %b/%b lvl %0d/%0d full %b/%b af %b/%b wen %b/%b ovf %b/%b (got/expected)",
                         $time, waddr_o, e.waddr, wptr_o, e.wptr, wlevel_o, e.lvl, full_o, e.full,
                         almost_full_o, e.af, wen_o, e.wen, ovf_a, e.ovf);
            end
            chk("gray_adjacent", ($countones(wptr_o ^ old) <= 1) ? 1 : 0, 1);
        end
    end

    initial begin
        #7;
        chk("rst_wptr", wptr_o, 0);
        chk("rst_waddr", waddr_o, 0);
        chk("rst_full", full_o, 0);
        chk("rst_af", almost_full_o, 0);
        chk("rst_lvl", wlevel_o, 0);
        chk("rst_wen", wen_o, 0);
        chk("rst_ovf", ovf_a, 0);
        #5 rstn_i = 1'b1;

        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 0);
            #2;
            if (i == 11) chk("af_before_12", almost_full_o, 0);
            if (i == 12) chk("af_at_12", almost_full_o, 1);
            if (i == 15) chk("not_full_15", full_o, 0);
        end
        chk("full_16", full_o, 1);
        chk("lvl_16", wlevel_o, 16);
        chk("wptr_16", wptr_o, 5'b11000);

        for (int i = 0; i < 3; i++) step(1'b1, 0);
        #2;
        chk("hold_wptr", wptr_o, 5'b11000);
        chk("hold_lvl", wlevel_o, 16);
        chk("hold_wen", wen_o, 0);
        step(1'b0, 0);
        #2;
`ifdef WPTR_OVF_FLAG_EN
        chk("ovf_sticky", ovf_a, 1);
`endif

        step(1'b0, 1);
        #2;
        chk("pop_full", full_o, 0);
        chk("pop_lvl", wlevel_o, 15);
        chk("pop_af", almost_full_o, 1);
        step(1'b1, 1);
        #2;
        chk("refull", full_o, 1);

        step(1'b0, (wcnt - 4 + 32) % 32);
        for (int i = 0; i < 64; i++) step(1'b1, (wcnt + 1 - 4 + 32) % 32);
        #2;
        chk("wrap_lvl", wlevel_o, 4);
        chk("wrap_full", full_o, 0);

        for (int i = 0; i < 5; i++) step(1'b1, 13);
        @(negedge clk_i);
        winc_i = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_wptr", wptr_o, 0);
        chk("arst_waddr", waddr_o, 0);
        chk("arst_lvl", wlevel_o, 0);
        chk("arst_full", full_o, 0);
        wcnt   = 0;
        full_m = 1'b0;
        ovf_m  = 1'b0;
        rptr_sync_i = '0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        step(1'b1, 0);
        #2;
        chk("post_rst_waddr", waddr_o, 1);
        chk("post_rst_wptr", wptr_o, 5'b00001);

        step(1'b0, 0);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/afifo_wptr_full.md
Name: afifo_wptr_full

Overview:
Write-side pointer and full-flag generator for the async FIFO.
- Keeps the binary write address and the registered Gray-coded write pointer. That pointer drives the read-domain dbl_sync directly (its data_i).
- Compares against the read pointer already synchronised into the write domain by the opposite dbl_sync to produce full, almost-full and fill level.
- Single write-clock domain.

Parameters:
ADDR_WIDTH, 4, memory address bits; depth = 2**ADDR_WIDTH; minimum 2; pointers are ADDR_WIDTH+1 bits
AFULL_THRESH, 12, fill level at or above which almost_full_o asserts; legal range 1..2**ADDR_WIDTH

Ports:
clk_i  input  1  write-domain clock
rstn_i  input  1  reset, asynchronous, active-low
winc_i  input  1  write request from producer
rptr_sync_i  input  ADDR_WIDTH+1  Gray read pointer, already double-synchronised into clk_i domain
wen_o  output  1  memory write strobe = winc_i & !full_o (combinational)
waddr_o  output  ADDR_WIDTH  memory write address = low bits of binary write pointer
wptr_o  output  ADDR_WIDTH+1  registered Gray write pointer, to read-domain dbl_sync
full_o  output  1  FIFO full, registered
almost_full_o  output  1  level >= AFULL_THRESH, registered
wlevel_o  output  ADDR_WIDTH+1  write-side fill level 0..2**ADDR_WIDTH, registered

Behaviour:
- Reset (rstn_i low, asynchronous): internal binary pointer wbin=0, wptr_o=0, waddr_o=0, full_o=0, almost_full_o=0, wlevel_o=0. wen_o follows winc_i. Outputs hold these values until the first clk_i rising edge after rstn_i deasserts.
- Push accepted iff winc_i=1 and full_o=0 at the rising edge.
  - Accepted: wbin_next = wbin+1, wrapping modulo 2**(ADDR_WIDTH+1).
  - Otherwise wbin_next = wbin.
- Gray encoding: wgray_next = wbin_next ^ (wbin_next >> 1).
  - wptr_o is a flop of wgray_next; there is no combinational path from inputs to wptr_o.
  - Consecutive wptr_o values differ in exactly one bit, or are equal. This includes the wrap 2**(ADDR_WIDTH+1)-1 -> 0.
  - The downstream synchroniser depends on this property.
- waddr_o = wbin[ADDR_WIDTH-1:0], registered.
- Latency: wptr_o, waddr_o, full_o, almost_full_o and wlevel_o all reflect a push on the same edge that accepts it (1-cycle register latency from winc_i).
- Full: full_next = (wgray_next == {~rptr_sync_i[MSB:MSB-1], rptr_sync_i[MSB-2:0]}). full_o <= full_next.
- Level: rbin = Gray-to-binary(rptr_sync_i) via XOR prefix from MSB. level_next = (wbin_next - rbin) mod 2**(ADDR_WIDTH+1). wlevel_o <= level_next.
- almost_full_o <= (level_next >= AFULL_THRESH).
- Simultaneous push and rptr_sync_i change: all flags are computed from wbin_next and the current rptr_sync_i. No priority logic is needed.
- Push while full: pointers unchanged, wen_o=0, data is dropped by the producer's contract.
- Full is pessimistic. A read-side pop is seen only after sync delay, and full_o deasserts on the first edge after rptr_sync_i advances. It is never optimistic.
- rptr_sync_i is trusted to be a valid Gray value; no checking is done here.

Optional Feature:
WPTR_OVF_FLAG_EN
- Defined: adds output port ovf_o (1 bit), a sticky overflow flag.
  - Set on any rising edge where winc_i=1 and full_o=1.
  - Cleared only by reset; reset value 0.
- Not defined: port ovf_o and its flop are absent; behaviour is otherwise identical.

Test Plan (ADDR_WIDTH=4, AFULL_THRESH=12):
1. Reset, rstn_i=0 with winc_i=0 -> all registered outputs 0; wen_o=0.
2. rptr_sync_i=0, 16 back-to-back pushes:
   - waddr_o steps 0..15.
   - wptr_o follows Gray 00,01,03,02,06,...
   - almost_full_o rises on the edge of the 12th push.
   - full_o=1 and wlevel_o=16 on the edge of the 16th push.
3. While full, hold winc_i=1 for 3 cycles:
   - wen_o=0.
   - wptr_o stays at 5'b11000; wlevel_o stays 16.
   - With WPTR_OVF_FLAG_EN, ovf_o=1 and remains 1 after winc_i drops.
4. From full, set rptr_sync_i=5'b00001 (read binary 1) -> next edge: full_o=0, wlevel_o=15, almost_full_o=1. One further push makes full_o=1 again.
5. Wrap: run 64 pushes with rptr_sync_i tracking Gray(wbin-4).
   - Every change of wptr_o is one-hot in (new ^ old), including 31->0.
   - full_o never asserts; wlevel_o stays 4.
6. Asynchronous reset mid-operation: after 5 pushes, drop rstn_i between clock edges -> wptr_o, waddr_o, wlevel_o go to 0 immediately without a clock edge. The first push after release gives waddr_o=1 and wptr_o=5'b00001.
